// File: rtl/plru_tree_nway.sv
// N-way tree pseudo-LRU state per set with invalid-first, lock-aware victim selection.
// Optional macro PLRU_AUTO_TOUCH_EN: an acknowledged victim is also made MRU.
module plru_tree_nway #(
  parameter int WAYS = 8,
  parameter int SETS = 128,
  parameter int SETW = $clog2(SETS),
  parameter int WAYW = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            init_busy,
  input  logic            upd_valid,
  input  logic [SETW-1:0] upd_set,
  input  logic [WAYW-1:0] upd_way,
  input  logic            vic_req,
  input  logic [SETW-1:0] vic_set,
  input  logic [WAYS-1:0] vic_valid_mask,
  input  logic [WAYS-1:0] vic_lock_mask,
  output logic            vic_ack,
  output logic [WAYW-1:0] vic_way,
  output logic            vic_none
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Heap-indexed tree bits, node 1 is the root; a 0 bit points the LRU side left.
  logic [WAYS-1:1] tree_q [SETS];

  logic [1:0]      state_q, state_d;
  logic [SETW-1:0] sweep_q, sweep_d;
  logic            vic_ack_q;
  logic [WAYW-1:0] vic_way_q;
  logic            vic_none_q;

  logic            run;
  logic            vic_in_range, upd_in_range;
  logic [SETW-1:0] vic_rd_set, upd_rd_set;
  logic [WAYS-1:1] vic_tree, upd_tree;
  logic            vic_fire, upd_fire;

  logic [WAYS-1:0]   cand;
  logic [2*WAYS-1:1] sub_locked;
  logic [WAYW-1:0]   node;
  logic              dir;
  logic [WAYW-1:0]   vic_way_c;
  logic              vic_none_c;

  // Mark every node on the path to way as pointing away from it.
  function automatic logic [WAYS-1:1] touch(input logic [WAYS-1:1] t_in,
                                            input logic [WAYW-1:0] way);
    logic [WAYS-1:1] t;
    logic [WAYW-1:0] n;
    t = t_in;
    n = WAYW'(1);
    for (int l = WAYW - 1; l >= 0; l--) begin
      t[n] = ~way[l];
      n    = WAYW'({n, way[l]});
    end
    return t;
  endfunction

  generate
    if (SETS == (1 << SETW)) begin : g_full_range
      assign vic_in_range = 1'b1;
      assign upd_in_range = 1'b1;
    end else begin : g_part_range
      assign vic_in_range = (int'(vic_set) < SETS);
      assign upd_in_range = (int'(upd_set) < SETS);
    end
  endgenerate

  assign run        = (state_q == ST_RUN);
  assign vic_rd_set = vic_in_range ? vic_set : '0;
  assign upd_rd_set = upd_in_range ? upd_set : '0;
  assign vic_tree   = tree_q[vic_rd_set];
  assign upd_tree   = tree_q[upd_rd_set];
  assign vic_fire   = run & vic_req;
  assign upd_fire   = run & upd_valid & upd_in_range;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q != ST_RUN) begin
      if (sweep_q == SETW'(SETS - 1)) begin
        state_d = ST_RUN;
        sweep_d = '0;
      end else begin
        state_d = ST_INIT;
        sweep_d = sweep_q + 1'b1;
      end
    end
  end

  always_comb begin
    cand       = ~vic_valid_mask & ~vic_lock_mask;
    sub_locked = '0;
    for (int w = 0; w < WAYS; w++) sub_locked[WAYS + w] = vic_lock_mask[w];
    for (int n = WAYS - 1; n >= 1; n--) sub_locked[n] = sub_locked[2*n] & sub_locked[2*n+1];
    node       = WAYW'(1);
    dir        = 1'b0;
    vic_way_c  = '0;
    vic_none_c = 1'b0;
    if (!vic_in_range) begin
      vic_none_c = 1'b1;
    end else if (|cand) begin
      for (int w = WAYS - 1; w >= 0; w--) if (cand[w]) vic_way_c = WAYW'(w);
    end else if (&vic_lock_mask) begin
      vic_none_c = 1'b1;
    end else begin
      // Root is not fully locked here, so steering away from locked subtrees always ends on a free leaf.
      for (int l = 0; l < WAYW; l++) begin
        dir = vic_tree[node];
        if (sub_locked[{node, dir}]) dir = ~dir;
        node = WAYW'({node, dir});
      end
      vic_way_c = node;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sweep_q    <= '0;
      vic_ack_q  <= 1'b0;
      vic_way_q  <= '0;
      vic_none_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      vic_ack_q <= vic_fire;
      if (vic_fire) begin
        vic_way_q  <= vic_way_c;
        vic_none_q <= vic_none_c;
      end
    end
  end

  // Tree storage carries no reset; the sweep clears it before any access is honoured.
  always_ff @(posedge clk) begin
    if (!run) begin
      tree_q[sweep_q] <= '0;
    end else begin
`ifdef PLRU_AUTO_TOUCH_EN
      if (vic_fire && !vic_none_c && !(upd_fire && (upd_set == vic_set)))
        tree_q[vic_rd_set] <= touch(vic_tree, vic_way_c);
`endif
      if (upd_fire) tree_q[upd_rd_set] <= touch(upd_tree, upd_way);
    end
  end

  assign init_busy = ~run;
  assign vic_ack   = vic_ack_q;
  assign vic_way   = vic_way_q;
  assign vic_none  = vic_none_q;

endmodule

// File: tb/tb_plru_tree_nway.sv
// Directed bench for plru_tree_nway: init sweep, updates, masks, locks, same-cycle and reset cases.
module tb_plru_tree_nway;

  localparam int WAYS   = 8;
  localparam int SETS   = 128;
  localparam int SETS_B = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_busy, upd_valid, vic_req, vic_ack, vic_none;
  logic [6:0] upd_set, vic_set;
  logic [2:0] upd_way, vic_way;
  logic [7:0] vic_valid_mask, vic_lock_mask;

  logic       b_init_busy, b_upd_valid, b_vic_req, b_vic_ack, b_vic_none;
  logic [6:0] b_upd_set, b_vic_set;
  logic [2:0] b_upd_way, b_vic_way;
  logic [7:0] b_vic_valid_mask, b_vic_lock_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  plru_tree_nway #(.WAYS(WAYS), .SETS(SETS)) u_dut (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .upd_valid(upd_valid), .upd_set(upd_set), .upd_way(upd_way),
    .vic_req(vic_req), .vic_set(vic_set),
    .vic_valid_mask(vic_valid_mask), .vic_lock_mask(vic_lock_mask),
    .vic_ack(vic_ack), .vic_way(vic_way), .vic_none(vic_none)
  );

  plru_tree_nway #(.WAYS(WAYS), .SETS(SETS_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .init_busy(b_init_busy),
    .upd_valid(b_upd_valid), .upd_set(b_upd_set), .upd_way(b_upd_way),
    .vic_req(b_vic_req), .vic_set(b_vic_set),
    .vic_valid_mask(b_vic_valid_mask), .vic_lock_mask(b_vic_lock_mask),
    .vic_ack(b_vic_ack), .vic_way(b_vic_way), .vic_none(b_vic_none)
  );

  task automatic do_upd(input int s, input int w);
    @(negedge clk);
    upd_valid = 1'b1;
    upd_set   = 7'(s);
    upd_way   = 3'(w);
    @(negedge clk);
    upd_valid = 1'b0;
    $display("upd  set=%0d way=%0d", s, w);
  endtask

  // Returns #1 after the edge that registers the ack.
  task automatic do_vic(input int s, input logic [7:0] v, input logic [7:0] l);
    @(negedge clk);
    vic_req        = 1'b1;
    vic_set        = 7'(s);
    vic_valid_mask = v;
    vic_lock_mask  = l;
    @(posedge clk);
    #1;
    vic_req = 1'b0;
    $display("vic  set=%0d valid=%h lock=%h -> ack=%0b way=%0d none=%0b", s, v, l, vic_ack, vic_way, vic_none);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    upd_valid = 1'b0; upd_set = '0; upd_way = '0;
    vic_req = 1'b0; vic_set = '0; vic_valid_mask = 8'hFF; vic_lock_mask = 8'h00;
    b_upd_valid = 1'b0; b_upd_set = '0; b_upd_way = '0;
    b_vic_req = 1'b0; b_vic_set = '0; b_vic_valid_mask = 8'hFF; b_vic_lock_mask = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({init_busy, vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%0b ack=%0b none=%0b way=%0d, want busy=1 ack=0 none=0 way=0",
               init_busy, vic_ack, vic_none, vic_way);
    end
  endtask

  task automatic test_init_sweep;
    int cycles;
    bit ack_seen;
    cycles = 0;
    ack_seen = 0;
    @(negedge clk);
    vic_req = 1'b1; vic_set = 7'd0; vic_valid_mask = 8'hFF; vic_lock_mask = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (vic_ack) ack_seen = 1;
      if (!init_busy) break;
    end
    $display("init sweep busy cycles=%0d", cycles);
    n_checks++;
    if (cycles != SETS) begin
      n_fail++;
      $display("FAIL init_busy_length: got %0d cycles, want %0d", cycles, SETS);
    end
    n_checks++;
    if (ack_seen) begin
      n_fail++;
      $display("FAIL ack_during_init: got an ack while init_busy, want none");
    end
    @(posedge clk);
    #1;
    vic_req = 1'b0;
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL first_ack_after_init: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=0",
               vic_ack, vic_none, vic_way);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (vic_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_single_pulse: got ack=%0b, want 0", vic_ack);
    end
  endtask

  task automatic test_update;
    logic [2:0] exp_way;
    for (int w = 0; w < WAYS; w++) do_upd(5, w);
    do_vic(5, 8'hFF, 8'h00);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL touch_all_victim: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=0",
               vic_ack, vic_none, vic_way);
    end
    do_upd(5, 0);
    do_vic(5, 8'hFF, 8'h00);
    exp_way = 3'd4;
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, exp_way}) begin
      n_fail++;
      $display("FAIL touch_way0_victim: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=%0d",
               vic_ack, vic_none, vic_way, exp_way);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({vic_ack, vic_way} !== {1'b0, exp_way}) begin
      n_fail++;
      $display("FAIL victim_hold: got ack=%0b way=%0d, want ack=0 way=%0d", vic_ack, vic_way, exp_way);
    end
  endtask

  task automatic test_masks;
    logic [2:0] exp_way;
    do_vic(5, 8'hEF, 8'h00);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL invalid_pref: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=4",
               vic_ack, vic_none, vic_way);
    end
    // Tree points at way 4, which is locked, so the walk flips to its sibling.
`ifdef PLRU_AUTO_TOUCH_EN
    exp_way = 3'd2;
`else
    exp_way = 3'd5;
`endif
    do_vic(5, 8'hEF, 8'h10);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, exp_way}) begin
      n_fail++;
      $display("FAIL locked_invalid_skipped: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=%0d",
               vic_ack, vic_none, vic_way, exp_way);
    end
    do_vic(11, 8'h0F, 8'h30);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd6}) begin
      n_fail++;
      $display("FAIL lowest_free_invalid: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=6",
               vic_ack, vic_none, vic_way);
    end
  endtask

  task automatic test_locks;
    do_vic(10, 8'hFF, 8'h0F);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL lock_low_half: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=4",
               vic_ack, vic_none, vic_way);
    end
    do_vic(10, 8'hFF, 8'hFF);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL all_locked_none: got ack=%0b none=%0b way=%0d, want ack=1 none=1 way=0",
               vic_ack, vic_none, vic_way);
    end
    do_vic(12, 8'hFF, 8'h7F);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd7}) begin
      n_fail++;
      $display("FAIL only_way7_free: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=7",
               vic_ack, vic_none, vic_way);
    end
    @(negedge clk);
    b_vic_req = 1'b1; b_vic_set = 7'd120;
    @(posedge clk);
    #1;
    b_vic_req = 1'b0;
    $display("vic  (sets=100) set=120 -> ack=%0b way=%0d none=%0b", b_vic_ack, b_vic_way, b_vic_none);
    n_checks++;
    if ({b_vic_ack, b_vic_none, b_vic_way} !== {1'b1, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL out_of_range_set: got ack=%0b none=%0b way=%0d, want ack=1 none=1 way=0",
               b_vic_ack, b_vic_none, b_vic_way);
    end
    @(negedge clk);
    b_vic_req = 1'b1; b_vic_set = 7'd99;
    @(posedge clk);
    #1;
    b_vic_req = 1'b0;
    $display("vic  (sets=100) set=99 -> ack=%0b way=%0d none=%0b", b_vic_ack, b_vic_way, b_vic_none);
    n_checks++;
    if ({b_vic_ack, b_vic_none, b_vic_way} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL last_valid_set: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=0",
               b_vic_ack, b_vic_none, b_vic_way);
    end
  endtask

  task automatic test_same_cycle;
    logic [2:0] exp_way;
    @(negedge clk);
    upd_valid = 1'b1; upd_set = 7'd3; upd_way = 3'd0;
    vic_req = 1'b1; vic_set = 7'd3; vic_valid_mask = 8'hFF; vic_lock_mask = 8'h00;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; vic_req = 1'b0;
    $display("upd+vic set=3 -> ack=%0b way=%0d none=%0b", vic_ack, vic_way, vic_none);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL read_before_write: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=0",
               vic_ack, vic_none, vic_way);
    end
    do_vic(3, 8'hFF, 8'h00);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL update_visible_next: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=4",
               vic_ack, vic_none, vic_way);
    end
    @(negedge clk);
    upd_valid = 1'b1; upd_set = 7'd7; upd_way = 3'd0;
    vic_req = 1'b1; vic_set = 7'd8;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; vic_req = 1'b0;
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL other_set_victim: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=0",
               vic_ack, vic_none, vic_way);
    end
`ifdef PLRU_AUTO_TOUCH_EN
    exp_way = 3'd4;
`else
    exp_way = 3'd0;
`endif
    do_vic(8, 8'hFF, 8'h00);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, exp_way}) begin
      n_fail++;
      $display("FAIL other_set_untouched: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=%0d",
               vic_ack, vic_none, vic_way, exp_way);
    end
    do_vic(7, 8'hFF, 8'h00);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL other_set_updated: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=4",
               vic_ack, vic_none, vic_way);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_way;
`ifdef PLRU_AUTO_TOUCH_EN
    exp_way = 3'd4;
`else
    exp_way = 3'd0;
`endif
    @(negedge clk);
    vic_req = 1'b1; vic_set = 7'd20; vic_valid_mask = 8'hFF; vic_lock_mask = 8'h00;
    @(posedge clk);
    #1;
    $display("vic  b2b#1 set=20 -> ack=%0b way=%0d none=%0b", vic_ack, vic_way, vic_none);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL b2b_first: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=0",
               vic_ack, vic_none, vic_way);
    end
    @(posedge clk);
    #1;
    vic_req = 1'b0;
    $display("vic  b2b#2 set=20 -> ack=%0b way=%0d none=%0b", vic_ack, vic_way, vic_none);
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, exp_way}) begin
      n_fail++;
      $display("FAIL b2b_second: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=%0d",
               vic_ack, vic_none, vic_way, exp_way);
    end
  endtask

  task automatic test_reset_mid;
    int cycles;
    bit ack_seen;
    do_vic(30, 8'hFF, 8'hFF);
    n_checks++;
    if ({vic_ack, vic_none} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_ack: got ack=%0b none=%0b, want ack=1 none=1", vic_ack, vic_none);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({init_busy, vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset_mid_request: got busy=%0b ack=%0b none=%0b way=%0d, want 1 0 0 0",
               init_busy, vic_ack, vic_none, vic_way);
    end
    ack_seen = 0;
    @(negedge clk);
    vic_req = 1'b1; vic_set = 7'd5; vic_valid_mask = 8'hFF; vic_lock_mask = 8'h00;
    rst_n = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (vic_ack) ack_seen = 1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({init_busy, vic_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: got busy=%0b ack=%0b, want busy=1 ack=0", init_busy, vic_ack);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (vic_ack) ack_seen = 1;
      if (!init_busy) break;
    end
    $display("re-init sweep busy cycles=%0d", cycles);
    n_checks++;
    if (cycles != SETS) begin
      n_fail++;
      $display("FAIL reinit_busy_length: got %0d cycles, want %0d", cycles, SETS);
    end
    n_checks++;
    if (ack_seen) begin
      n_fail++;
      $display("FAIL ack_during_reinit: got an ack while busy or in reset, want none");
    end
    @(posedge clk);
    #1;
    vic_req = 1'b0;
    n_checks++;
    if ({vic_ack, vic_none, vic_way} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL tree_cleared_after_reinit: got ack=%0b none=%0b way=%0d, want ack=1 none=0 way=0",
               vic_ack, vic_none, vic_way);
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_update();
    test_masks();
    test_locks();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
